// File: rtl/rx_phy_defs.sv
// Shared RX PHY definitions: comma symbol, byte geometry and FSM states.
// No ports; imported by desplazador_serial and deserializador_activo.
package rx_phy_defs;

    localparam int         BYTE_W    = 8;
    localparam int         BITCNT_W  = $clog2(BYTE_W);
    localparam logic [7:0] COMMA_SYM = 8'hBC;

    typedef enum logic {
        BUSCANDO = 1'b0,
        ACTIVO   = 1'b1
    } estado_t;

endpackage

// File: rtl/desplazador_serial.sv
// Serial-to-parallel shifter with byte boundary counter.
// Ports: clk, reset (sync, active-high), data_in (serial, MSB first),
//        align (forces the next bit to start a new byte),
//        byte_w (byte including the current bit), byte_done (bit 0 now).
module desplazador_serial
    import rx_phy_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in,
    input  logic              align,
    output logic [BYTE_W-1:0] byte_w,
    output logic              byte_done
);

    // Only the 7 most recent bits are stored; the oldest one falls out
    // of the window as soon as the current bit is appended.
    logic [BYTE_W-2:0]   sr;
    logic [BITCNT_W-1:0] bit_cnt;

    assign byte_w    = {sr, data_in};
    assign byte_done = (bit_cnt == BITCNT_W'(BYTE_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr <= byte_w[BYTE_W-2:0];
            if (align) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + BITCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/deserializador_activo.sv
// RX deserializer with COMMA-based link training (raises sticky active).
// Ports: clk, reset (sync, active-high), data_in (serial, MSB first),
//        data_out (last payload byte), valid_out (new payload byte strobe),
//        active (link trained), comma_cnt (consecutive aligned COMMAs).
// Option: define DESERIALIZADOR_ALIGN_EN to snap the byte boundary onto
//         any COMMA seen while searching.
module deserializador_activo
    import rx_phy_defs::*;
#(
    parameter logic [7:0] COMMA            = COMMA_SYM,
    parameter int         COMMAS_TO_ACTIVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active,
    output logic [3:0]        comma_cnt
);

    localparam logic [3:0] CNT_MAX = 4'(COMMAS_TO_ACTIVE);

    estado_t           state, state_n;
    logic [3:0]        cnt_n;
    logic [BYTE_W-1:0] dout_n;
    logic              vout_n;
    logic [BYTE_W-1:0] byte_w;
    logic              byte_done;
    logic              is_comma;
    logic              hit;
    logic              align;

    desplazador_serial u_desplazador (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .align     (align),
        .byte_w    (byte_w),
        .byte_done (byte_done)
    );

    assign is_comma = (byte_w == COMMA);
    assign active   = (state == ACTIVO);

    always_comb begin
        state_n = state;
        cnt_n   = comma_cnt;
        dout_n  = data_out;
        vout_n  = 1'b0;
        align   = 1'b0;
`ifdef DESERIALIZADOR_ALIGN_EN
        // Any bit position may hold a COMMA while searching.
        hit = is_comma && (state == BUSCANDO);
`else
        hit = is_comma && byte_done;
`endif
        unique case (state)
            BUSCANDO: begin
                if (hit) begin
                    // Only reachable below CNT_MAX: hitting it leaves.
                    cnt_n = comma_cnt + 4'd1;
`ifdef DESERIALIZADOR_ALIGN_EN
                    align = 1'b1;
`endif
                    if (cnt_n == CNT_MAX) begin
                        state_n = ACTIVO;
                    end
                end else if (byte_done) begin
                    cnt_n = '0;
                end
            end
            ACTIVO: begin
                // comma_cnt stays saturated; COMMAs are idle fill.
                if (byte_done && !is_comma) begin
                    dout_n = byte_w;
                    vout_n = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BUSCANDO;
            comma_cnt <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_n;
            comma_cnt <= cnt_n;
            data_out  <= dout_n;
            valid_out <= vout_n;
        end
    end

endmodule
